// File: rtl/shifter_pkg.sv
// Shared definitions for the normalizer / barrel-shifter datapath.
// Direction encodings match the barrel shifter's lr control.
package shifter_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic             dir;
    logic             zero;
  } norm_result_t;

  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

endpackage

// File: rtl/lzc_32.sv
// Combinational leading-zero counter: count of zeros above the highest set bit.
// An all-zero input reports cnt_o=0 with zero_o=1.
module lzc_32
  import shifter_pkg::*;
(
  input  logic [WIDTH-1:0] data_i,
  output logic [SHW-1:0]   cnt_o,
  output logic             zero_o
);

  // Scanning upward lets the highest set bit win the priority.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) cnt_o = SHW'(WIDTH - 1 - i);
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/shift_normalizer_32b.sv
// Two-stage normalizer: stage A holds the word and counts zeros, stage B shifts
// it and holds the result; valid/ready on both sides with full throughput.
module shift_normalizer_32b
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   shft_amt,
  output logic             out_dir,
  output logic             zero
);

  logic             a_valid_q, a_valid_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic             a_dir_q, a_dir_d;
  logic             b_valid_q, b_valid_d;
  norm_result_t     res_q, res_d;

  logic [WIDTH-1:0] lzc_in;
  logic [SHW-1:0]   cnt;
  logic             all_zero;
  logic             b_load;

  // Trailing zeros of a word are the leading zeros of its mirror image.
  assign lzc_in = (a_dir_q == DIR_RIGHT) ? bit_reverse(a_data_q) : a_data_q;

  lzc_32 u_lzc (
    .data_i (lzc_in),
    .cnt_o  (cnt),
    .zero_o (all_zero)
  );

  logic [WIDTH-1:0] lvl [SHW+1];
  assign lvl[0] = a_data_q;

  generate
    for (genvar gi = 0; gi < SHW; gi++) begin : g_shift
      assign lvl[gi+1] = !cnt[gi]                ? lvl[gi] :
                         (a_dir_q == DIR_RIGHT)  ? (lvl[gi] >> (1 << gi)) :
                                                   (lvl[gi] << (1 << gi));
    end
  endgenerate

  assign b_load   = !b_valid_q || out_ready;
  assign in_ready = !a_valid_q || b_load;

  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    a_dir_d   = a_dir_q;
    b_valid_d = b_valid_q;
    res_d     = res_q;
    if (in_ready) begin
      a_valid_d = in_valid;
      if (in_valid) begin
        a_data_d = in_data;
        a_dir_d  = dir;
      end
    end
    // Result fields only change on a real load so a stalled output stays put.
    if (b_load) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        res_d.data = lvl[SHW];
        res_d.amt  = cnt;
        res_d.dir  = a_dir_q;
        res_d.zero = all_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_dir_q   <= DIR_LEFT;
      b_valid_q <= 1'b0;
      res_q     <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      a_dir_q   <= a_dir_d;
      b_valid_q <= b_valid_d;
      res_q     <= res_d;
    end
  end

  assign out_valid = b_valid_q;
  assign out_data  = res_q.data;
  assign shft_amt  = res_q.amt;
  assign out_dir   = res_q.dir;
  assign zero      = res_q.zero;

endmodule

// File: tb/tb_shift_normalizer_32b.sv
// Self-checking bench for shift_normalizer_32b: directed corner cases, streaming,
// backpressure, mid-flight reset and a randomized run against a reference model.
module tb_shift_normalizer_32b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        dir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  shft_amt;
  logic        out_dir;
  logic        zero;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  shift_normalizer_32b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dir       (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .shft_amt  (shft_amt),
    .out_dir   (out_dir),
    .zero      (zero)
  );

  // Reference: slide the word toward the chosen edge one bit at a time and count.
  function automatic logic [38:0] ref_norm(input logic [31:0] d, input logic dr);
    logic [31:0] w;
    int          n;
    w = d;
    n = 0;
    if (d != 32'd0) begin
      while ((dr == 1'b0 ? w[31] : w[0]) == 1'b0) begin
        w = (dr == 1'b0) ? (w << 1) : (w >> 1);
        n++;
      end
    end
    return {w, n[4:0], dr, (d == 32'd0)};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; dir = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({out_valid, out_data, shft_amt, out_dir, zero} !== 40'd0)
      $display("FAIL reset_outputs: got v=%b d=%h a=%0d dir=%b z=%b, want all zero",
               out_valid, out_data, shft_amt, out_dir, zero);
    else pass_cnt++;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    else pass_cnt++;
    $display("txn reset: outputs cleared, in_ready=%b", in_ready);
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [31:0] v_in   [8];
    logic        v_dir  [8];
    logic [31:0] v_data [8];
    logic [4:0]  v_amt  [8];
    logic        v_zero [8];
    v_in[0] = 32'h1234_5678; v_dir[0] = 0; v_data[0] = 32'h91A2_B3C0; v_amt[0] = 3;  v_zero[0] = 0;
    v_in[1] = 32'h1234_5678; v_dir[1] = 1; v_data[1] = 32'h0246_8ACF; v_amt[1] = 3;  v_zero[1] = 0;
    v_in[2] = 32'h0000_0001; v_dir[2] = 0; v_data[2] = 32'h8000_0000; v_amt[2] = 31; v_zero[2] = 0;
    v_in[3] = 32'h8000_0000; v_dir[3] = 1; v_data[3] = 32'h0000_0001; v_amt[3] = 31; v_zero[3] = 0;
    v_in[4] = 32'hFFFF_FFFF; v_dir[4] = 0; v_data[4] = 32'hFFFF_FFFF; v_amt[4] = 0;  v_zero[4] = 0;
    v_in[5] = 32'hFFFF_FFFF; v_dir[5] = 1; v_data[5] = 32'hFFFF_FFFF; v_amt[5] = 0;  v_zero[5] = 0;
    v_in[6] = 32'h0000_0000; v_dir[6] = 0; v_data[6] = 32'h0000_0000; v_amt[6] = 0;  v_zero[6] = 1;
    v_in[7] = 32'h0000_0000; v_dir[7] = 1; v_data[7] = 32'h0000_0000; v_amt[7] = 0;  v_zero[7] = 1;
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = v_in[i]; dir = v_dir[i];
      @(negedge clk);
      chk_cnt++;
      if (in_ready !== 1'b1) $display("FAIL directed_in_ready[%0d]: got %b want 1", i, in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL directed_early[%0d]: out_valid=%b want 0", i, out_valid);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (out_valid !== 1'b1 || out_data !== v_data[i] || shft_amt !== v_amt[i] ||
          out_dir !== v_dir[i] || zero !== v_zero[i])
        $display("FAIL directed[%0d]: got v=%b d=%h a=%0d dir=%b z=%b want v=1 d=%h a=%0d dir=%b z=%b",
                 i, out_valid, out_data, shft_amt, out_dir, zero,
                 v_data[i], v_amt[i], v_dir[i], v_zero[i]);
      else pass_cnt++;
      $display("txn directed in=%h dir=%b -> d=%h amt=%0d zero=%b", v_in[i], v_dir[i], out_data, shft_amt, zero);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h1234_5678; dir = 1'b0;
    @(posedge clk); #1;
    dir = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h91A2_B3C0 || shft_amt !== 5'd3 || out_dir !== 1'b0)
      $display("FAIL b2b_first: got v=%b d=%h a=%0d dir=%b want 1 91a2b3c0 3 0", out_valid, out_data, shft_amt, out_dir);
    else pass_cnt++;
    $display("txn b2b first d=%h amt=%0d", out_data, shft_amt);
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'h0246_8ACF || shft_amt !== 5'd3 || out_dir !== 1'b1)
      $display("FAIL b2b_second: got v=%b d=%h a=%0d dir=%b want 1 02468acf 3 1", out_valid, out_data, shft_amt, out_dir);
    else pass_cnt++;
    $display("txn b2b second d=%h amt=%0d", out_data, shft_amt);
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drained: out_valid=%b want 0", out_valid);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [31:0] words [4];
    logic [4:0]  amts  [4];
    int          sent = 0;
    int          got_n = 0;
    logic [38:0] prev = '0;
    bit          prev_stall = 0;
    words[0] = 32'h10; words[1] = 32'h20; words[2] = 32'h40; words[3] = 32'h80;
    amts[0] = 27; amts[1] = 26; amts[2] = 25; amts[3] = 24;
    for (int cyc = 0; cyc < 16; cyc++) begin
      in_valid = (sent < 4);
      in_data = (sent < 4) ? words[sent] : 32'h0;
      dir = 1'b0;
      out_ready = (cyc >= 6);
      @(negedge clk);
      if (sent == 2 && !out_ready) begin
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, in_ready);
        else pass_cnt++;
      end
      if (prev_stall) begin
        chk_cnt++;
        if (out_valid !== 1'b1 || {out_data, shft_amt, out_dir, zero} !== prev)
          $display("FAIL bp_stable cyc%0d: got v=%b %h want v=1 %h", cyc, out_valid,
                   {out_data, shft_amt, out_dir, zero}, prev);
        else pass_cnt++;
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (got_n >= 4 || out_data !== 32'h8000_0000 || shft_amt !== amts[got_n])
          $display("FAIL bp_result[%0d]: got d=%h a=%0d want d=80000000 a=%0d", got_n, out_data, shft_amt,
                   (got_n < 4) ? amts[got_n] : 5'd0);
        else pass_cnt++;
        $display("txn bp result %0d d=%h amt=%0d", got_n, out_data, shft_amt);
        got_n++;
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_data, shft_amt, out_dir, zero};
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (got_n !== 4 || sent !== 4) $display("FAIL bp_count: got %0d results of %0d sent, want 4/4", got_n, sent);
    else pass_cnt++;
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hAAAA_0000; dir = 1'b0;
    @(posedge clk); #1;
    in_data = 32'h0000_5555; dir = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL rst_full: out_valid=%b want 1", out_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rst_async: out_valid=%b want 0", out_valid);
    else pass_cnt++;
    in_valid = 1'b1; in_data = 32'h1357_9BDF; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL rst_held: out_valid=%b want 0", out_valid);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL rst_empty[%0d]: in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h00F0_0000; dir = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'hF000_0000 || shft_amt !== 5'd8 || zero !== 1'b0)
      $display("FAIL rst_after: got v=%b d=%h a=%0d z=%b want 1 f0000000 8 0", out_valid, out_data, shft_amt, zero);
    else pass_cnt++;
    $display("txn post-reset d=%h amt=%0d", out_data, shft_amt);
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [38:0] exp_q [$];
    logic [38:0] e;
    logic [38:0] got;
    logic [38:0] prev = '0;
    bit          prev_stall = 0;
    logic [31:0] r;
    for (int cyc = 0; cyc < 160; cyc++) begin
      r = $urandom();
      in_valid = (cyc < 120) && ($urandom_range(0, 3) != 0);
      in_data = $urandom_range(0, 1) ? (r >> $urandom_range(0, 31)) : (r << $urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) in_data = 32'h0;
      dir = 1'($urandom_range(0, 1));
      out_ready = (cyc >= 120) || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      got = {out_data, shft_amt, out_dir, zero};
      if (prev_stall) begin
        chk_cnt++;
        if (out_valid !== 1'b1 || got !== prev)
          $display("FAIL rand_stable cyc%0d: got v=%b %h want v=1 %h", cyc, out_valid, got, prev);
        else pass_cnt++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_norm(in_data, dir));
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_spurious cyc%0d: got %h with nothing expected", cyc, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) $display("FAIL rand_result cyc%0d: got %h want %h", cyc, got, e);
          else pass_cnt++;
          $display("txn rand d=%h amt=%0d dir=%b zero=%b", out_data, shft_amt, out_dir, zero);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev = got;
      @(posedge clk); #1;
    end
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL rand_lost: %0d results never appeared, want 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; dir = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
